// File: rtl/rename_pkg.sv
// Shared entry type and width helpers for the multi-port register rename table.
package rename_pkg;

    // Widest physical index an entry can hold; the table checks its PW against this.
    localparam int unsigned RT_PREG_W = 10;

    typedef struct packed {
        logic                 pending;
        logic [RT_PREG_W-1:0] preg;
    } rt_entry_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/FreeListPicker.sv
// Picks the p_alloc_ports lowest-index free physical registers and counts a free vector.
// A pick of 0 means "no register available" since p0 is never free.
module FreeListPicker
    import rename_pkg::*;
#(
    parameter  int unsigned p_num_phys_regs = 64,
    parameter  int unsigned p_alloc_ports   = 2,
    localparam int unsigned PW              = idx_w(p_num_phys_regs),
    localparam int unsigned CW              = cnt_w(p_num_phys_regs)
) (
    input  logic [p_num_phys_regs-1:0]         free_i,
    input  logic [p_num_phys_regs-1:0]         count_vec_i,
    output logic [p_alloc_ports-1:0][PW-1:0]   pick_o,
    output logic [CW-1:0]                      count_o
);

    logic [p_num_phys_regs-1:0] avail;
    logic                       found;

    // Successive lowest-set-bit extraction, one pass per allocation port.
    always_comb begin
        avail  = free_i;
        found  = 1'b0;
        pick_o = '0;
        for (int k = 0; k < int'(p_alloc_ports); k++) begin
            found = 1'b0;
            for (int i = 0; i < int'(p_num_phys_regs); i++) begin
                if (!found && avail[i]) begin
                    pick_o[k] = PW'(i);
                    avail[i]  = 1'b0;
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(p_num_phys_regs); i++) begin
            count_o = count_o + CW'(count_vec_i[i]);
        end
    end

endmodule

// File: rtl/multi_rename_table.sv
// Multi-port register rename table: speculative map, committed map and free list.
// Optional macro RENAME_COMPLETE_BYPASS_EN lets a same-cycle completion clear lookup_pending_o.
module multi_rename_table
    import rename_pkg::*;
#(
    parameter  int unsigned p_num_arch_regs = 32,
    parameter  int unsigned p_num_phys_regs = 64,
    parameter  int unsigned p_alloc_ports   = 2,
    parameter  int unsigned p_lookup_ports  = 4,
    localparam int unsigned AW              = idx_w(p_num_arch_regs),
    localparam int unsigned PW              = idx_w(p_num_phys_regs),
    localparam int unsigned CW              = cnt_w(p_num_phys_regs)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_alloc_ports-1:0]            alloc_en_i,
    input  logic [p_alloc_ports-1:0][AW-1:0]    alloc_areg_i,
    output logic [p_alloc_ports-1:0][PW-1:0]    alloc_preg_o,
    output logic [p_alloc_ports-1:0][PW-1:0]    alloc_ppreg_o,
    output logic                                alloc_rdy_o,
    input  logic [p_lookup_ports-1:0][AW-1:0]   lookup_areg_i,
    output logic [p_lookup_ports-1:0][PW-1:0]   lookup_preg_o,
    output logic [p_lookup_ports-1:0]           lookup_pending_o,
    input  logic                                complete_val_i,
    input  logic [PW-1:0]                       complete_preg_i,
    input  logic                                commit_val_i,
    input  logic [AW-1:0]                       commit_areg_i,
    input  logic [PW-1:0]                       commit_preg_i,
    input  logic [PW-1:0]                       commit_ppreg_i,
    input  logic                                squash_i,
    output logic [CW-1:0]                       free_count_o
);

    if (p_num_phys_regs < p_num_arch_regs + p_alloc_ports) begin : g_bad_reg_counts
        $error("multi_rename_table: p_num_phys_regs must be >= p_num_arch_regs + p_alloc_ports");
    end
    if (PW > RT_PREG_W) begin : g_bad_preg_width
        $error("multi_rename_table: physical index wider than rt_entry_t.preg");
    end

    rt_entry_t                    spec_q [p_num_arch_regs];
    rt_entry_t                    spec_d [p_num_arch_regs];
    logic [PW-1:0]                cmap_q [p_num_arch_regs];
    logic [PW-1:0]                cmap_d [p_num_arch_regs];
    logic [p_num_phys_regs-1:0]   free_q, free_d, refd_vec;
    logic [CW-1:0]                free_count_q, free_count_d;
    logic [p_alloc_ports-1:0][PW-1:0] pick;
    logic [p_alloc_ports-1:0]     consume, xfer;
    int                           rank;

    FreeListPicker #(
        .p_num_phys_regs (p_num_phys_regs),
        .p_alloc_ports   (p_alloc_ports)
    ) u_picker (
        .free_i      (free_q),
        .count_vec_i (free_d),
        .pick_o      (pick),
        .count_o     (free_count_d)
    );

    // Allocation outputs: consuming ports take picks in order, later ports forward from earlier ones.
    always_comb begin
        rank          = 0;
        alloc_rdy_o   = (free_count_q >= CW'(p_alloc_ports)) && !squash_i;
        alloc_preg_o  = '0;
        alloc_ppreg_o = '0;
        consume       = '0;
        xfer          = '0;
        for (int k = 0; k < int'(p_alloc_ports); k++) begin
            consume[k] = alloc_en_i[k] && (alloc_areg_i[k] != '0);
            xfer[k]    = consume[k] && alloc_rdy_o;
            if (consume[k]) begin
                for (int s = 0; s < int'(p_alloc_ports); s++) begin
                    if (rank == s) alloc_preg_o[k] = pick[s];
                end
                rank = rank + 1;
                alloc_ppreg_o[k] = PW'(spec_q[alloc_areg_i[k]].preg);
                for (int j = 0; j < k; j++) begin
                    if (consume[j] && (alloc_areg_i[j] == alloc_areg_i[k])) begin
                        alloc_ppreg_o[k] = alloc_preg_o[j];
                    end
                end
            end
        end
    end

    // Lookups read registered state only; same-cycle allocations are invisible.
    always_comb begin
        lookup_preg_o    = '0;
        lookup_pending_o = '0;
        for (int l = 0; l < int'(p_lookup_ports); l++) begin
            if (lookup_areg_i[l] != '0) begin
                lookup_preg_o[l]    = PW'(spec_q[lookup_areg_i[l]].preg);
                lookup_pending_o[l] = spec_q[lookup_areg_i[l]].pending;
`ifdef RENAME_COMPLETE_BYPASS_EN
                if (complete_val_i && (complete_preg_i == lookup_preg_o[l])) begin
                    lookup_pending_o[l] = 1'b0;
                end
`endif
            end
        end
    end

    // Next state: reset > squash (rebuild from committed map) > complete/alloc/commit.
    always_comb begin
        spec_d   = spec_q;
        cmap_d   = cmap_q;
        free_d   = free_q;
        refd_vec = '0;
        if (rst) begin
            for (int i = 0; i < int'(p_num_arch_regs); i++) begin
                spec_d[i] = '{pending: 1'b0, preg: RT_PREG_W'(i)};
                cmap_d[i] = PW'(i);
            end
            for (int p = 0; p < int'(p_num_phys_regs); p++) begin
                free_d[p] = (p >= int'(p_num_arch_regs));
            end
        end else begin
            if (commit_val_i && (commit_areg_i != '0)) begin
                cmap_d[commit_areg_i] = commit_preg_i;
            end
            if (squash_i) begin
                for (int i = 0; i < int'(p_num_arch_regs); i++) begin
                    spec_d[i]           = '{pending: 1'b0, preg: RT_PREG_W'(cmap_d[i])};
                    refd_vec[cmap_d[i]] = 1'b1;
                end
                free_d    = ~refd_vec;
                free_d[0] = 1'b0;
            end else begin
                if (complete_val_i) begin
                    for (int i = 0; i < int'(p_num_arch_regs); i++) begin
                        if (spec_q[i].preg == RT_PREG_W'(complete_preg_i)) spec_d[i].pending = 1'b0;
                    end
                end
                for (int k = 0; k < int'(p_alloc_ports); k++) begin
                    if (xfer[k]) begin
                        spec_d[alloc_areg_i[k]] = '{pending: 1'b1, preg: RT_PREG_W'(alloc_preg_o[k])};
                        free_d[alloc_preg_o[k]] = 1'b0;
                    end
                end
                if (commit_val_i && (commit_ppreg_i != '0)) begin
                    free_d[commit_ppreg_i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        spec_q       <= spec_d;
        cmap_q       <= cmap_d;
        free_q       <= free_d;
        free_count_q <= free_count_d;
    end

    assign free_count_o = free_count_q;

`ifndef SYNTHESIS
    function automatic string trace(int level);
        string s;
        s = $sformatf("free_count=%0d free=%h", free_count_q, free_q);
        if (level > 0) begin
            for (int i = 1; i < int'(p_num_arch_regs); i++) begin
                s = {s, $sformatf(" x%0d:p%0d%s", i, spec_q[i].preg, spec_q[i].pending ? "*" : "")};
            end
        end
        return s;
    endfunction
`endif

endmodule

// File: tb/tb_multi_rename_table.sv
// Scoreboard bench for multi_rename_table: expectations queued at stimulus, compared after sampling.
module tb_multi_rename_table;

    localparam int unsigned NA = 32;
    localparam int unsigned NP = 64;
    localparam int unsigned AP = 2;
    localparam int unsigned LP = 4;
`ifdef RENAME_COMPLETE_BYPASS_EN
    localparam int BYP_PEND = 0;
`else
    localparam int BYP_PEND = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       alloc_en;
    logic [1:0][4:0]  alloc_areg;
    logic [1:0][5:0]  alloc_preg, alloc_ppreg;
    logic             alloc_rdy;
    logic [3:0][4:0]  lookup_areg;
    logic [3:0][5:0]  lookup_preg;
    logic [3:0]       lookup_pending;
    logic             complete_val;
    logic [5:0]       complete_preg;
    logic             commit_val;
    logic [4:0]       commit_areg;
    logic [5:0]       commit_preg, commit_ppreg;
    logic             squash;
    logic [6:0]       free_count;

    multi_rename_table #(
        .p_num_arch_regs (NA),
        .p_num_phys_regs (NP),
        .p_alloc_ports   (AP),
        .p_lookup_ports  (LP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_en_i       (alloc_en),
        .alloc_areg_i     (alloc_areg),
        .alloc_preg_o     (alloc_preg),
        .alloc_ppreg_o    (alloc_ppreg),
        .alloc_rdy_o      (alloc_rdy),
        .lookup_areg_i    (lookup_areg),
        .lookup_preg_o    (lookup_preg),
        .lookup_pending_o (lookup_pending),
        .complete_val_i   (complete_val),
        .complete_preg_i  (complete_preg),
        .commit_val_i     (commit_val),
        .commit_areg_i    (commit_areg),
        .commit_preg_i    (commit_preg),
        .commit_ppreg_i   (commit_ppreg),
        .squash_i         (squash),
        .free_count_o     (free_count)
    );

    string       sb_name[$];
    logic [31:0] sb_exp[$];
    logic [31:0] sb_obs[$];
    int          checks = 0;
    int          passed = 0;

    task automatic expect_val(input string name, input int v);
        sb_name.push_back(name);
        sb_exp.push_back(32'(v));
    endtask

    task automatic observe(input logic [31:0] v);
        sb_obs.push_back(v);
    endtask

    task automatic exp_lookup(input int p, input int preg, input int pend);
        expect_val($sformatf("lookup%0d_preg", p), preg);
        expect_val($sformatf("lookup%0d_pend", p), pend);
    endtask

    task automatic obs_lookups();
        for (int p = 0; p < int'(LP); p++) begin
            observe(32'(lookup_preg[p]));
            observe(32'(lookup_pending[p]));
        end
    endtask

    task automatic set_lookups(input int a0, input int a1, input int a2, input int a3);
        lookup_areg[0] = 5'(a0);
        lookup_areg[1] = 5'(a1);
        lookup_areg[2] = 5'(a2);
        lookup_areg[3] = 5'(a3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_en      = '0;
        alloc_areg    = '0;
        complete_val  = 1'b0;
        complete_preg = '0;
        commit_val    = 1'b0;
        commit_areg   = '0;
        commit_preg   = '0;
        commit_ppreg  = '0;
        squash        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        set_lookups(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e, o;
        string nm;
        do_reset();
        alloc_en = 2'b01; alloc_areg[0] = 5'd5;
        tick();
        // reset must beat alloc, squash, commit and complete in the same cycle
        rst = 1'b1;
        alloc_en = 2'b11; alloc_areg[0] = 5'd5; alloc_areg[1] = 5'd6;
        squash = 1'b1; complete_val = 1'b1; complete_preg = 6'd32;
        commit_val = 1'b1; commit_areg = 5'd5; commit_preg = 6'd32; commit_ppreg = 6'd5;
        expect_val("free_count", 32);
        expect_val("alloc_rdy", 1);
        exp_lookup(0, 0, 0); exp_lookup(1, 5, 0); exp_lookup(2, 6, 0); exp_lookup(3, 31, 0);
        tick();
        rst = 1'b0; idle(); set_lookups(0, 5, 6, 31);
        #1;
        observe(32'(free_count)); observe(32'(alloc_rdy)); obs_lookups();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_reset %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    task automatic test_alloc_basic();
        logic [31:0] e, o;
        string nm;
        do_reset();
        alloc_en = 2'b11; alloc_areg[0] = 5'd5; alloc_areg[1] = 5'd6;
        set_lookups(5, 6, 0, 0);
        expect_val("alloc_preg0", 32); expect_val("alloc_preg1", 33);
        expect_val("alloc_ppreg0", 5); expect_val("alloc_ppreg1", 6);
        expect_val("alloc_rdy", 1);    expect_val("free_count_pre", 32);
        exp_lookup(0, 5, 0);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1]));
        observe(32'(alloc_ppreg[0])); observe(32'(alloc_ppreg[1]));
        observe(32'(alloc_rdy)); observe(32'(free_count));
        observe(32'(lookup_preg[0])); observe(32'(lookup_pending[0]));
        expect_val("free_count_post", 30);
        exp_lookup(0, 32, 1); exp_lookup(1, 33, 1); exp_lookup(2, 0, 0); exp_lookup(3, 0, 0);
        tick(); idle();
        #1;
        observe(32'(free_count)); obs_lookups();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_alloc_basic %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    task automatic test_intra_group();
        logic [31:0] e, o;
        string nm;
        do_reset();
        alloc_en = 2'b11; alloc_areg[0] = 5'd7; alloc_areg[1] = 5'd7;
        expect_val("dup_preg0", 32); expect_val("dup_preg1", 33);
        expect_val("dup_ppreg0", 7); expect_val("dup_ppreg1", 32);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1]));
        observe(32'(alloc_ppreg[0])); observe(32'(alloc_ppreg[1]));
        tick();
        // disabled port consumes nothing, next port takes the lowest free
        alloc_en = 2'b10; alloc_areg[0] = 5'd3; alloc_areg[1] = 5'd9;
        set_lookups(7, 0, 0, 0);
        expect_val("dis_preg0", 0); expect_val("dis_ppreg0", 0);
        expect_val("dis_preg1", 34); expect_val("dis_ppreg1", 9);
        exp_lookup(0, 33, 1);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_ppreg[0]));
        observe(32'(alloc_preg[1])); observe(32'(alloc_ppreg[1]));
        observe(32'(lookup_preg[0])); observe(32'(lookup_pending[0]));
        tick();
        alloc_en = 2'b11; alloc_areg[0] = 5'd0; alloc_areg[1] = 5'd10;
        expect_val("x0_preg0", 0); expect_val("x0_preg1", 35); expect_val("free_count_mid", 29);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1])); observe(32'(free_count));
        tick(); idle(); set_lookups(9, 10, 0, 3);
        expect_val("free_count_end", 28);
        exp_lookup(0, 34, 1); exp_lookup(1, 35, 1); exp_lookup(2, 0, 0); exp_lookup(3, 3, 0);
        #1;
        observe(32'(free_count)); obs_lookups();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_intra_group %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    task automatic test_complete();
        logic [31:0] e, o;
        string nm;
        do_reset();
        alloc_en = 2'b01; alloc_areg[0] = 5'd5;
        tick(); idle();
        complete_val = 1'b1; complete_preg = 6'd32;
        set_lookups(5, 6, 0, 5);
        exp_lookup(0, 32, BYP_PEND); exp_lookup(1, 6, 0); exp_lookup(2, 0, 0); exp_lookup(3, 32, BYP_PEND);
        #1;
        obs_lookups();
        tick(); idle();
        exp_lookup(0, 32, 0); exp_lookup(1, 6, 0); exp_lookup(2, 0, 0); exp_lookup(3, 32, 0);
        #1;
        obs_lookups();
        // alloc to x5 in the same cycle that its new preg completes: alloc wins
        alloc_en = 2'b01; alloc_areg[0] = 5'd5; complete_val = 1'b1; complete_preg = 6'd33;
        expect_val("realloc_preg0", 33); expect_val("realloc_ppreg0", 32);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_ppreg[0]));
        tick(); idle();
        exp_lookup(0, 33, 1); exp_lookup(1, 6, 0); exp_lookup(2, 0, 0); exp_lookup(3, 33, 1);
        #1;
        obs_lookups();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_complete %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    task automatic test_exhaust();
        logic [31:0] e, o;
        string nm;
        do_reset();
        // x(n+1) -> p(32+n) for n = 0..30, leaving only p63 free
        for (int n = 0; n < 31; n += 2) begin
            alloc_en      = (n + 1 < 31) ? 2'b11 : 2'b01;
            alloc_areg[0] = 5'(n + 1);
            alloc_areg[1] = 5'((n + 2) % 32);
            tick();
        end
        idle();
        alloc_en = 2'b11; alloc_areg[0] = 5'd1; alloc_areg[1] = 5'd2;
        expect_val("low_free_count", 1); expect_val("low_rdy", 0);
        expect_val("low_preg0", 63);     expect_val("low_preg1", 0);
        #1;
        observe(32'(free_count)); observe(32'(alloc_rdy));
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1]));
        tick();
        commit_val = 1'b1; commit_areg = 5'd5; commit_preg = 6'd36; commit_ppreg = 6'd5;
        expect_val("commit_cyc_count", 1); expect_val("commit_cyc_rdy", 0); expect_val("commit_cyc_preg0", 63);
        #1;
        observe(32'(free_count)); observe(32'(alloc_rdy)); observe(32'(alloc_preg[0]));
        tick();
        commit_val = 1'b0; commit_areg = '0; commit_preg = '0; commit_ppreg = '0;
        expect_val("freed_count", 2); expect_val("freed_rdy", 1);
        expect_val("freed_preg0", 5); expect_val("freed_preg1", 63); expect_val("freed_ppreg0", 32);
        #1;
        observe(32'(free_count)); observe(32'(alloc_rdy));
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1])); observe(32'(alloc_ppreg[0]));
        tick(); idle(); set_lookups(1, 2, 5, 31);
        expect_val("empty_count", 0); expect_val("empty_rdy", 0);
        exp_lookup(0, 5, 1); exp_lookup(1, 63, 1); exp_lookup(2, 36, 1); exp_lookup(3, 62, 1);
        #1;
        observe(32'(free_count)); observe(32'(alloc_rdy)); obs_lookups();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_exhaust %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    task automatic test_squash();
        logic [31:0] e, o;
        string nm;
        do_reset();
        alloc_en = 2'b01; alloc_areg[0] = 5'd5;
        tick(); idle();
        squash = 1'b1; alloc_en = 2'b11; alloc_areg[0] = 5'd6; alloc_areg[1] = 5'd7;
        complete_val = 1'b1; complete_preg = 6'd32;
        expect_val("squash_rdy", 0);
        #1;
        observe(32'(alloc_rdy));
        tick(); idle(); set_lookups(5, 6, 7, 0);
        expect_val("squash_count", 32);
        exp_lookup(0, 5, 0); exp_lookup(1, 6, 0); exp_lookup(2, 7, 0); exp_lookup(3, 0, 0);
        #1;
        observe(32'(free_count)); obs_lookups();
        alloc_en = 2'b01; alloc_areg[0] = 5'd5;
        tick(); idle();
        squash = 1'b1; commit_val = 1'b1; commit_areg = 5'd5; commit_preg = 6'd32; commit_ppreg = 6'd5;
        tick(); idle();
        alloc_en = 2'b01; alloc_areg[0] = 5'd9;
        expect_val("sqc_count", 32); expect_val("sqc_rdy", 1); expect_val("sqc_preg0", 5);
        exp_lookup(0, 32, 0); exp_lookup(1, 6, 0); exp_lookup(2, 7, 0); exp_lookup(3, 0, 0);
        #1;
        observe(32'(free_count)); observe(32'(alloc_rdy)); observe(32'(alloc_preg[0])); obs_lookups();
        tick(); idle();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_squash %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, o;
        string nm;
        do_reset();
        alloc_en = 2'b11; alloc_areg[0] = 5'd10; alloc_areg[1] = 5'd11;
        expect_val("b1_preg0", 32); expect_val("b1_preg1", 33);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1]));
        tick();
        alloc_areg[0] = 5'd10; alloc_areg[1] = 5'd12;
        set_lookups(10, 11, 0, 0);
        expect_val("b2_preg0", 34); expect_val("b2_preg1", 35);
        expect_val("b2_ppreg0", 32); expect_val("b2_ppreg1", 12);
        exp_lookup(0, 32, 1); exp_lookup(1, 33, 1); exp_lookup(2, 0, 0); exp_lookup(3, 0, 0);
        #1;
        observe(32'(alloc_preg[0])); observe(32'(alloc_preg[1]));
        observe(32'(alloc_ppreg[0])); observe(32'(alloc_ppreg[1])); obs_lookups();
        tick(); idle();
        expect_val("b3_count", 28);
        exp_lookup(0, 34, 1); exp_lookup(1, 33, 1); exp_lookup(2, 0, 0); exp_lookup(3, 0, 0);
        #1;
        observe(32'(free_count)); obs_lookups();
        while (sb_exp.size() != 0) begin
            nm = sb_name.pop_front(); e = sb_exp.pop_front();
            o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 'x;
            checks++;
            if (o !== e) $display("FAIL test_back_to_back %s: got %0d expected %0d", nm, o, e);
            else passed++;
        end
        sb_obs.delete();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_lookups(0, 0, 0, 0);
        test_reset();
        test_alloc_basic();
        test_intra_group();
        test_complete();
        test_exhaust();
        test_squash();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_rename_table.md
MULTI_RENAME_TABLE -- requirements
Module: multi_rename_table

Interface
REQ-001 The module SHALL have parameter p_num_arch_regs, default 32, the number of architectural registers; x0 is never renamed.
REQ-002 The module SHALL have parameter p_num_phys_regs, default 64, the number of physical registers; p0 is hardwired zero and never allocated.
REQ-003 The module SHALL have parameter p_alloc_ports, default 2, the number of rename allocations per cycle.
REQ-004 The module SHALL have parameter p_lookup_ports, default 4, the number of source lookups per cycle.
REQ-005 The module SHALL have derived widths AW=$clog2(p_num_arch_regs), PW=$clog2(p_num_phys_regs) and CW=$clog2(p_num_phys_regs+1).
REQ-006 The module SHALL have these ports, with clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_en  in  [p_alloc_ports]  per-port allocate request
- alloc_areg  in  AW x p_alloc_ports  destination architectural register
- alloc_preg  out  PW x p_alloc_ports  new physical register
- alloc_ppreg  out  PW x p_alloc_ports  previous mapping
- alloc_rdy  out  1  group may allocate
- lookup_areg  in  AW x p_lookup_ports  source architectural register
- lookup_preg  out  PW x p_lookup_ports  mapped physical register
- lookup_pending  out  [p_lookup_ports]  value not yet produced
- complete  CompleteNotif.sub  val, preg
- commit  CommitNotif.sub  val, areg, preg, ppreg
- squash  in  1  restore the committed state
- free_count  out  CW  number of free physical registers

Function
REQ-007 The module SHALL keep a speculative map (preg plus pending per areg), a committed map (preg per areg) and a free bit vector (p1..p_num_phys_regs-1).
REQ-008 alloc_rdy SHALL be 1 iff free_count >= p_alloc_ports and squash=0; allocation is all-or-nothing per group.
REQ-009 alloc_preg[k] SHALL be the k-th lowest-index free preg; ports with alloc_en=0 or areg=0 SHALL consume nothing and output preg 0.
REQ-010 On xfer (alloc_rdy & alloc_en[k] & areg!=0), the speculative map[areg] SHALL become {preg, pending=1}, and the free bit SHALL clear on the next edge.
REQ-011 When the same areg is allocated on ports j<k in one cycle, port k SHALL win the map entry, and alloc_ppreg[k] SHALL equal alloc_preg[j] (intra-group forwarding); otherwise alloc_ppreg SHALL equal the current map entry.
REQ-012 Lookups SHALL be combinational from the current speculative map, SHALL NOT see same-cycle allocations, and areg 0 SHALL return {0, pending=0}.
REQ-013 complete.val SHALL clear pending on every speculative entry whose preg equals complete.preg; if an alloc to the same areg occurs in the same cycle, the alloc SHALL win.
REQ-014 commit.val SHALL set committedmap[areg]=preg and set free[ppreg]=1 on the next edge; ppreg 0 SHALL be ignored.
REQ-015 A preg freed in cycle t SHALL NOT be allocatable before cycle t+1.
REQ-016 On squash, the next state SHALL be:
- speculative map = committed map after the same-cycle commit, with all pending=0
- free = every preg not referenced by that committed map
- same-cycle alloc and complete ignored
REQ-017 free_count SHALL equal the popcount of the free vector, registered alongside it.

Reset
REQ-018 On rst, both maps SHALL hold map[i]=i with pending=0.
REQ-019 On rst, free[i]=1 SHALL hold iff i >= p_num_arch_regs, so free_count = p_num_phys_regs - p_num_arch_regs.
REQ-020 rst SHALL override squash, commit, complete and alloc in the same cycle.
REQ-021 A parameter check SHALL fail elaboration unless p_num_phys_regs >= p_num_arch_regs + p_alloc_ports.

Configuration
REQ-022 With RENAME_COMPLETE_BYPASS_EN defined, lookup_pending SHALL be forced 0 when complete.val=1 and complete.preg equals the looked-up preg in the same cycle.
REQ-023 Without RENAME_COMPLETE_BYPASS_EN, lookup_pending SHALL reflect only registered state, so completion becomes visible one cycle later.

Structure
REQ-024 The rt_entry_t typedef (pending, preg) and the width functions SHALL live in the shared package rename_pkg.
REQ-025 Multi-pick free selection (p_alloc_ports lowest set bits, plus popcount) SHALL be the sub-module FreeListPicker.
REQ-026 Non-synthesis code SHALL provide a trace(int level) function.

Verification
REQ-027 After reset, alloc x5 and x6 -> alloc_preg={32,33}, alloc_ppreg={5,6}, free_count goes 32->30, and a lookup of x5 next cycle gives {32, pending=1}.
REQ-028 Same-cycle alloc of x7 on ports 0 and 1 -> pregs 32 and 33, port 1 ppreg=32, and a later lookup of x7 gives 33.
REQ-029 complete preg 32 in the cycle of a lookup of x5 -> pending=0 that cycle with the bypass macro and 1 without; pending=0 in both cases next cycle.
REQ-030 Allocate until free_count=1 -> alloc_rdy=0; commit with ppreg=5 -> next cycle free_count=2, alloc_rdy=1, alloc_preg[0]=5.
REQ-031 Alloc x5->32, then squash with no commit -> lookup of x5 gives {5,0}, free_count=32; squash with same-cycle commit (x5, preg 32, ppreg 5) -> lookup of x5 gives {32,0}, free_count=32.
REQ-032 rst asserted during alloc+squash -> all maps identity, free_count=32, alloc_rdy=1 next cycle.
